// File: rtl/sg_reader_pkg.sv
// rtl/sg_reader_pkg.sv - shared element type, layout constants and word-count helper for the SG list reader
package sg_reader_pkg;

    localparam int SG_ELEM_WIDTH = 128;
    localparam int SG_ADDR_LSB   = 0;
    localparam int SG_LEN_LSB    = 64;

    typedef struct packed {
        logic [31:0] rsvd;
        logic [31:0] len;
        logic [63:0] addr;
    } sg_elem_t;

    function automatic int sg_words_per_elem(input int data_width);
        return SG_ELEM_WIDTH / data_width;
    endfunction

endpackage

// File: rtl/sg_elem_queue.sv
// rtl/sg_elem_queue.sv - register FIFO of decoded SG elements with the head always in entry 0
module sg_elem_queue
    import sg_reader_pkg::*;
#(
    parameter int  C_DEPTH = 4,
    localparam int OCC_W   = $clog2(C_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  sg_elem_t         push_data,
    input  logic             pop,
    output sg_elem_t         head,
    output logic [OCC_W-1:0] occupancy
);

    sg_elem_t         mem       [C_DEPTH];
    sg_elem_t         mem_shift [C_DEPTH];
    logic             pop_ok;
    logic [OCC_W-1:0] wr_pos;

    assign pop_ok = pop && (occupancy != '0);
    // A push lands just behind the surviving entries after this cycle's shift.
    assign wr_pos = occupancy - OCC_W'(pop_ok);
    assign head   = mem[0];

    always_comb begin
        for (int i = 0; i < C_DEPTH - 1; i++) begin
            mem_shift[i] = mem[i + 1];
        end
        mem_shift[C_DEPTH - 1] = mem[C_DEPTH - 1];
    end

    // Entry 0 is only overwritten by a real successor or a push, so the head
    // keeps its last value once the queue drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
            for (int i = 0; i < C_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop_ok);
            for (int i = 0; i < C_DEPTH; i++) begin
                if (push && (OCC_W'(i) == wr_pos)) begin
                    mem[i] <= push_data;
                end else if (pop_ok && ((i + 1) < int'(occupancy))) begin
                    mem[i] <= mem_shift[i];
                end
            end
        end
    end

endmodule

// File: rtl/sg_list_reader_param.sv
// rtl/sg_list_reader_param.sv - SG element assembler, slot reservation and flush; SGR_ZERO_LEN_DROP_EN drops zero-length elements
module sg_list_reader_param
    import sg_reader_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 128,
    parameter int C_DEPTH       = 4,
    parameter int C_COUNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FLUSH,
    input  logic [C_DATA_WIDTH-1:0]  BUF_DATA,
    input  logic                     BUF_DATA_EMPTY,
    output logic                     BUF_DATA_REN,
    output logic                     VALID,
    output logic                     EMPTY,
    input  logic                     REN,
    output logic [63:0]              ADDR,
    output logic [31:0]              LEN,
    output logic [C_COUNT_WIDTH-1:0] ELEM_COUNT
);

    localparam int W   = sg_words_per_elem(C_DATA_WIDTH);
    localparam int S_W = $clog2(C_DEPTH + 1);

    if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128)) begin : g_bad_width
        $error("sg_list_reader_param: C_DATA_WIDTH must be 32, 64 or 128");
    end
    if (C_DEPTH < 2 || C_DEPTH > 16 || (C_DEPTH & (C_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sg_list_reader_param: C_DEPTH must be a power of two in 2..16");
    end

    logic [1:0]               wi;
    logic [S_W-1:0]           s_cnt;
    logic                     rd_pending;
    logic [1:0]               rd_idx;
    logic [SG_ELEM_WIDTH-1:0] elem_acc;
    logic [SG_ELEM_WIDTH-1:0] assembled;
    logic                     accept;
    logic                     push_ready;
    logic                     drop;
    logic                     q_push;
    logic                     pop_ok;
    logic [S_W-1:0]           q_occ;
    sg_elem_t                 head;
    logic                     unused_rsvd;

    // s_cnt counts queued plus in-assembly elements, so a new element is only
    // started when a queue slot is guaranteed for it.
    assign BUF_DATA_REN = RST_N && !FLUSH && ((wi != 2'd0) || (s_cnt < S_W'(C_DEPTH)));
    assign accept       = BUF_DATA_REN && !BUF_DATA_EMPTY;
    assign pop_ok       = REN && VALID && !FLUSH;

    always_comb begin
        assembled = elem_acc;
        assembled[int'(rd_idx) * C_DATA_WIDTH +: C_DATA_WIDTH] = BUF_DATA;
    end

    // Data returning during FLUSH belongs to the discarded stream.
    assign push_ready = rd_pending && (rd_idx == 2'(W - 1)) && !FLUSH;

`ifdef SGR_ZERO_LEN_DROP_EN
    assign drop = push_ready && (assembled[SG_LEN_LSB +: 32] == 32'd0);
`else
    assign drop = 1'b0;
`endif

    assign q_push = push_ready && !drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wi         <= 2'd0;
            rd_pending <= 1'b0;
            rd_idx     <= 2'd0;
            elem_acc   <= '0;
        end else begin
            rd_pending <= accept;
            if (accept) begin
                rd_idx <= wi;
            end
            if (FLUSH) begin
                wi <= 2'd0;
            end else if (accept) begin
                wi <= (wi == 2'(W - 1)) ? 2'd0 : wi + 2'd1;
            end
            if (rd_pending) begin
                elem_acc <= assembled;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_cnt <= '0;
        end else if (FLUSH) begin
            s_cnt <= '0;
        end else begin
            s_cnt <= s_cnt + S_W'(accept && (wi == 2'd0)) - S_W'(pop_ok) - S_W'(drop);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ELEM_COUNT <= '0;
        end else if (pop_ok) begin
            ELEM_COUNT <= ELEM_COUNT + C_COUNT_WIDTH'(1);
        end
    end

    sg_elem_queue #(
        .C_DEPTH (C_DEPTH)
    ) u_queue (
        .clk       (CLK),
        .rst_n     (RST_N),
        .flush     (FLUSH),
        .push      (q_push),
        .push_data (sg_elem_t'(assembled)),
        .pop       (pop_ok),
        .head      (head),
        .occupancy (q_occ)
    );

    assign VALID       = (q_occ != '0);
    assign ADDR        = head[SG_ADDR_LSB +: 64];
    assign LEN         = head.len;
    assign EMPTY       = BUF_DATA_EMPTY && (q_occ == '0) && (wi == 2'd0) && !rd_pending;
    assign unused_rsvd = ^head.rsvd;

endmodule

// File: tb/tb_sg_list_reader_param.sv
// tb/tb_sg_list_reader_param.sv - scoreboard bench for sg_list_reader_param with 32-bit words and depth 2
module tb_sg_list_reader_param;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 16;
    localparam int W     = 128 / DW;
`ifdef SGR_ZERO_LEN_DROP_EN
    localparam bit DROP_ZERO = 1'b1;
`else
    localparam bit DROP_ZERO = 1'b0;
`endif

    logic          CLK;
    logic          RST_N;
    logic          FLUSH;
    logic [DW-1:0] BUF_DATA;
    logic          BUF_DATA_EMPTY;
    logic          BUF_DATA_REN;
    logic          VALID;
    logic          EMPTY;
    logic          REN;
    logic [63:0]   ADDR;
    logic [31:0]   LEN;
    logic [CW-1:0] ELEM_COUNT;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] up_q[$];
    int            checks    = 0;
    int            errors    = 0;
    int            accepts   = 0;
    int            gap_pct   = 0;
    int            exp_total = 0;

    sg_list_reader_param #(
        .C_DATA_WIDTH  (DW),
        .C_DEPTH       (DEPTH),
        .C_COUNT_WIDTH (CW)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .FLUSH          (FLUSH),
        .BUF_DATA       (BUF_DATA),
        .BUF_DATA_EMPTY (BUF_DATA_EMPTY),
        .BUF_DATA_REN   (BUF_DATA_REN),
        .VALID          (VALID),
        .EMPTY          (EMPTY),
        .REN            (REN),
        .ADDR           (ADDR),
        .LEN            (LEN),
        .ELEM_COUNT     (ELEM_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Element layout {rsvd, len, addr}; word k carries bits [k*DW +: DW].
    task automatic load_elem(input logic [63:0] addr, input logic [31:0] len, input logic [31:0] rsvd);
        logic [127:0] e;
        e = {rsvd, len, addr};
        for (int k = 0; k < W; k++) begin
            up_q.push_back(e[k*DW +: DW]);
        end
        if (!(DROP_ZERO && len == 32'd0)) begin
            exp_q.push_back('{addr, len});
            exp_total++;
        end
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!VALID && n < max) begin
            tick();
            n++;
        end
        check("valid_timeout", VALID, 1);
    endtask

    task automatic wait_idle(input int max, input bit rnd_ren);
        int n;
        n = 0;
        while (!(EMPTY && up_q.size() == 0) && n < max) begin
            REN = rnd_ren ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        REN = 1'b0;
        check("drain_timeout", n < max, 1);
        check("drain_left", exp_q.size(), 0);
    endtask

    // Upstream SG buffer: data appears the cycle after an accepted read.
    initial begin
        bit acc;
        BUF_DATA       = '0;
        BUF_DATA_EMPTY = 1'b1;
        forever begin
            @(negedge CLK);
            acc = BUF_DATA_REN && !BUF_DATA_EMPTY && RST_N;
            @(posedge CLK);
            #1;
            if (acc && up_q.size() != 0) begin
                BUF_DATA = up_q.pop_front();
                accepts++;
            end
            BUF_DATA_EMPTY = (up_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
        end
    end

    // Monitor: every accepted pop must match the next expected element.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && !FLUSH && VALID && REN) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_addr", ADDR, e.addr);
                    check("pop_len", LEN, e.len);
                end
            end
            if (RST_N && dut.q_push) begin
                check("push_room", (int'(dut.q_occ) < DEPTH) || dut.pop_ok, 1);
            end
        end
    end

    initial begin
        int base;
        int n;
        int lat;
        RST_N = 1'b0;
        FLUSH = 1'b0;
        REN   = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_buf_ren", BUF_DATA_REN, 0);
        check("rst_valid", VALID, 0);
        check("rst_addr", ADDR, 0);
        check("rst_len", LEN, 0);
        check("rst_elem_count", ELEM_COUNT, 0);
        check("rst_empty", EMPTY, 1);
        RST_N = 1'b1;
        tick();

        // Three elements with REN held: first accept to VALID is W+1 cycles.
        REN  = 1'b1;
        base = accepts;
        load_elem(64'h1000, 32'd16, $urandom);
        load_elem(64'h2000, 32'd32, $urandom);
        load_elem(64'h3000, 32'd64, $urandom);
        n = 0;
        while (accepts == base && n < 50) begin
            tick();
            n++;
        end
        lat = 1;
        while (!VALID && lat < 50) begin
            tick();
            lat++;
        end
        check("latency_accept_to_valid", lat, W + 1);
        wait_idle(200, 1'b0);
        check("count_after_3", ELEM_COUNT, 16'(exp_total));
        check("empty_after_3", EMPTY, 1);

        // Words 0x1000, 0x1, 0x80, 0xDEADBEEF.
        REN = 1'b0;
        load_elem(64'h0000_0001_0000_1000, 32'h80, 32'hDEAD_BEEF);
        wait_valid(100);
        check("asm_addr", ADDR, 64'h0000_0001_0000_1000);
        check("asm_len", LEN, 32'h80);
        wait_idle(100, 1'b0);

        // Backpressure: only DEPTH elements are fetched until a pop frees a slot.
        REN  = 1'b0;
        base = accepts;
        for (int i = 0; i < 5; i++) begin
            load_elem({$urandom, $urandom}, 32'($urandom_range(1, 4096)), $urandom);
        end
        repeat (40) tick();
        check("bp_accepts", accepts - base, DEPTH * W);
        check("bp_buf_ren", BUF_DATA_REN, 0);
        check("bp_valid", VALID, 1);
        check("bp_occupancy", dut.q_occ, DEPTH);
        REN = 1'b1;
        tick();
        REN = 1'b0;
        repeat (30) tick();
        check("bp_accepts_after_pop", accepts - base, (DEPTH + 1) * W);
        check("bp_buf_ren_after_pop", BUF_DATA_REN, 0);
        wait_idle(400, 1'b1);

        // Flush with one element queued, wi==2 and a word in flight.
        REN  = 1'b0;
        base = accepts;
        load_elem(64'h5000, 32'd5, 32'd0);
        for (int k = 0; k < 2; k++) begin
            up_q.push_back($urandom);
        end
        n = 0;
        while ((accepts - base) < (W + 2) && n < 100) begin
            tick();
            n++;
        end
        check("flush_pre_valid", VALID, 1);
        FLUSH = 1'b1;
        REN   = 1'b1;
        exp_total -= exp_q.size();
        exp_q.delete();
        tick();
        FLUSH = 1'b0;
        REN   = 1'b0;
        check("flush_valid", VALID, 0);
        check("flush_empty", EMPTY, 1);
        check("flush_count", ELEM_COUNT, 16'(exp_total));
        load_elem(64'hABCD_0000_1234, 32'd7, $urandom);
        wait_idle(200, 1'b0);
        check("flush_then_count", ELEM_COUNT, 16'(exp_total));

        // Zero-length element in the middle of the stream.
        load_elem(64'h8000, 32'd8, 32'd0);
        load_elem(64'h9000, 32'd0, 32'd0);
        load_elem(64'hA000, 32'd4, 32'd0);
        wait_idle(300, 1'b0);
        check("zl_count", ELEM_COUNT, 16'(exp_total));
        check("zl_resv_zero", dut.s_cnt, 0);

        // Random elements, random empty gaps and random REN.
        gap_pct = 30;
        for (int i = 0; i < 60; i++) begin
            load_elem({$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                REN = 1'($urandom_range(0, 1));
                tick();
            end
        end
        wait_idle(5000, 1'b1);
        gap_pct = 0;
        check("rand_count", ELEM_COUNT, 16'(exp_total));

        // Asynchronous reset off the clock edge.
        REN = 1'b0;
        load_elem(64'hFEED_0000, 32'd9, 32'd0);
        load_elem(64'hBEEF_0000, 32'd3, 32'd0);
        wait_valid(100);
        tick();
        #1;
        RST_N = 1'b0;
        #1;
        check("arst_buf_ren", BUF_DATA_REN, 0);
        check("arst_valid", VALID, 0);
        check("arst_addr", ADDR, 0);
        check("arst_len", LEN, 0);
        check("arst_elem_count", ELEM_COUNT, 0);
        exp_q.delete();
        up_q.delete();
        exp_total = 0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (3) tick();
        check("post_rst_empty", EMPTY, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
